range_sum_engine: RTL and testbench

Parametrised arithmetic-series accumulator: sums every term `lo, lo+step, lo+2*step, …` up to and including the last term `<= hi`. It takes a start/ready request handshake and returns the result on a valid/ready handshake. It reports invalid ranges and sum overflow, and supports synchronous abort. It replaces the fixed 1..100 summing controller/datapath pair and sits as a memory-less compute slave behind the team's command sequencer.

---
 rtl/range_sum_pkg.sv | 14 +
 rtl/range_sum_ctrl.sv | 47 ++++
 rtl/range_sum_engine.sv | 97 +++++++++
 tb/tb_range_sum_engine.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/range_sum_pkg.sv
// Shared types and default widths for the arithmetic-series accumulator.
package range_sum_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_SUM_W  = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t LOAD  = 2'd1;
  localparam state_t COUNT = 2'd2;
  localparam state_t HOLD  = 2'd3;

endpackage

// File: rtl/range_sum_ctrl.sv
// Sequencing FSM: accepts a request, loads the operands, counts terms, holds the result.
module range_sum_ctrl
  import range_sum_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic result_ready,
  input  logic range_bad,
  input  logic last_term,
  output logic ld,
  output logic en,
  output logic start_ready,
  output logic busy,
  output logic result_valid
);

  state_t state;

  // State register; abort returns to IDLE ahead of any handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start)        state <= LOAD;
        LOAD:    state <= range_bad ? HOLD : COUNT;
        COUNT:   if (last_term)    state <= HOLD;
        HOLD:    if (result_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is a pure decode of the registered state.
  always_comb begin
    ld           = (state == LOAD);
    en           = (state == COUNT);
    start_ready  = (state == IDLE);
    busy         = (state == LOAD) || (state == COUNT);
    result_valid = (state == HOLD);
  end

endmodule

// File: rtl/range_sum_engine.sv
// Arithmetic-series accumulator: sums lo, lo+step, ... up to the last term <= hi.
module range_sum_engine
  import range_sum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] step,
  input  logic              abort,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [SUM_W-1:0]  result,
  output logic              err,
  output logic              overflow
);

  logic [DATA_W-1:0] lo_r;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] step_r;
  logic [DATA_W-1:0] counter;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W:0]    sum_ext;
  logic [DATA_W:0]   nxt;
  logic              range_bad;
  logic              last_term;
  logic              accept;
  logic              ld;
  logic              en;

  range_sum_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .result_ready (result_ready),
    .range_bad    (range_bad),
    .last_term    (last_term),
    .ld           (ld),
    .en           (en),
    .start_ready  (start_ready),
    .busy         (busy),
    .result_valid (result_valid)
  );

  // Range checks and the one-bit-wider next term, so hi at full scale cannot wrap.
  always_comb begin
    accept    = start && start_ready && !abort;
    range_bad = (step_r == '0) || (lo_r > hi_r);
    nxt       = {1'b0, counter} + {1'b0, step_r};
    last_term = nxt > {1'b0, hi_r};
    sum_ext   = {1'b0, sum} + {{(SUM_W + 1 - DATA_W){1'b0}}, counter};
  end

  // Operand capture, term counter, accumulator and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_r     <= '0;
      hi_r     <= '0;
      step_r   <= '0;
      counter  <= '0;
      sum      <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
    end else if (abort) begin
      sum      <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        lo_r   <= lo;
        hi_r   <= hi;
        step_r <= step;
      end
      if (ld) begin
        counter  <= lo_r;
        sum      <= '0;
        overflow <= 1'b0;
        err      <= range_bad;
      end
      if (en) begin
        sum      <= sum_ext[SUM_W-1:0];
        overflow <= overflow | sum_ext[SUM_W];
        counter  <= nxt[DATA_W-1:0];
      end
    end
  end

  assign result = sum;

endmodule

// File: tb/tb_range_sum_engine.sv
// Directed self-checking bench for range_sum_engine (default and 14-bit-sum instances).
module tb_range_sum_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        result_ready = 1'b0;
  logic [7:0]  lo = '0;
  logic [7:0]  hi = '0;
  logic [7:0]  step = '0;

  logic        start_ready, busy, result_valid, err, overflow;
  logic [15:0] result;

  logic        start_ready14, busy14, result_valid14, err14, overflow14;
  logic [13:0] result14;

  int tests = 0;
  int fails = 0;
  int edges;

  range_sum_engine dut (
    .clk (clk), .rst (rst), .start (start), .start_ready (start_ready),
    .lo (lo), .hi (hi), .step (step), .abort (abort), .busy (busy),
    .result_valid (result_valid), .result_ready (result_ready),
    .result (result), .err (err), .overflow (overflow)
  );

  range_sum_engine #(.DATA_W(8), .SUM_W(14)) dut14 (
    .clk (clk), .rst (rst), .start (start), .start_ready (start_ready14),
    .lo (lo), .hi (hi), .step (step), .abort (abort), .busy (busy14),
    .result_valid (result_valid14), .result_ready (result_ready),
    .result (result14), .err (err14), .overflow (overflow14)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a request and return #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] l, input logic [7:0] h, input logic [7:0] s);
    @(negedge clk);
    lo = l; hi = h; step = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges from the accept edge until result_valid is seen, bounded.
  task automatic waitValid(output int n);
    n = 0;
    while (!result_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rst_start_ready", start_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", result_valid, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;

    // Basic 1..100
    result_ready = 1'b1;
    applyStimulus(8'd1, 8'd100, 8'd1);
    checkOutput("basic_busy_load", busy, 1);
    checkOutput("basic_start_ready", start_ready, 0);
    waitValid(edges);
    checkOutput("basic_latency", edges, 101);
    checkOutput("basic_result", result, 5050);
    checkOutput("basic_err", err, 0);
    checkOutput("basic_overflow", overflow, 0);
    @(posedge clk); #1;
    checkOutput("basic_valid_one_cycle", result_valid, 0);
    checkOutput("basic_back_idle", start_ready, 1);

    // Stepped 3..20 by 4
    applyStimulus(8'd3, 8'd20, 8'd4);
    waitValid(edges);
    checkOutput("step_latency", edges, 6);
    checkOutput("step_result", result, 55);
    checkOutput("step_err", err, 0);
    @(posedge clk); #1;

    // lo == hi at full scale
    applyStimulus(8'd255, 8'd255, 8'd7);
    waitValid(edges);
    checkOutput("single_latency", edges, 2);
    checkOutput("single_result", result, 255);
    checkOutput("single_err", err, 0);
    @(posedge clk); #1;

    // Invalid: step 0
    applyStimulus(8'd5, 8'd10, 8'd0);
    waitValid(edges);
    checkOutput("step0_latency", edges, 1);
    checkOutput("step0_err", err, 1);
    checkOutput("step0_result", result, 0);
    @(posedge clk); #1;

    // Invalid: lo > hi
    applyStimulus(8'd9, 8'd2, 8'd1);
    waitValid(edges);
    checkOutput("lohi_latency", edges, 1);
    checkOutput("lohi_err", err, 1);
    checkOutput("lohi_result", result, 0);
    @(posedge clk); #1;

    // Overflow on the 14-bit instance, 0..255
    applyStimulus(8'd0, 8'd255, 8'd1);
    waitValid(edges);
    checkOutput("ovf_latency", edges, 257);
    checkOutput("ovf14_result", result14, 16256);
    checkOutput("ovf14_flag", overflow14, 1);
    checkOutput("ovf14_valid", result_valid14, 1);
    checkOutput("ovf16_result", result, 32640);
    checkOutput("ovf16_flag", overflow, 0);
    @(posedge clk); #1;

    // Backpressure, ignored start in COUNT, back-to-back restart
    result_ready = 1'b0;
    applyStimulus(8'd1, 8'd10, 8'd1);
    @(posedge clk); #1;
    @(negedge clk);
    lo = 8'd50; hi = 8'd60; step = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("ignore_busy", busy, 1);
    waitValid(edges);
    checkOutput("bp_result", result, 55);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_valid_hold", result_valid, 1);
      checkOutput("bp_result_stable", result, 55);
    end
    @(negedge clk);
    result_ready = 1'b1;
    lo = 8'd2; hi = 8'd4; step = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_valid_low", result_valid, 0);
    checkOutput("hs_idle", start_ready, 1);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("retrig_busy", busy, 1);
    waitValid(edges);
    checkOutput("retrig_latency", edges, 4);
    checkOutput("retrig_result", result, 9);
    @(posedge clk); #1;

    // Abort during COUNT
    applyStimulus(8'd1, 8'd100, 8'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_start_ready", start_ready, 1);
    checkOutput("abort_valid", result_valid, 0);
    checkOutput("abort_result", result, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_stays_idle", start_ready, 1);

    // Reset while holding a result
    result_ready = 1'b0;
    applyStimulus(8'd3, 8'd20, 8'd4);
    waitValid(edges);
    checkOutput("pre_rst_valid", result_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_valid", result_valid, 0);
    checkOutput("arst_start_ready", start_ready, 1);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_result", result, 0);
    checkOutput("arst_err", err, 0);
    checkOutput("arst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    result_ready = 1'b1;
    applyStimulus(8'd1, 8'd100, 8'd1);
    waitValid(edges);
    checkOutput("post_rst_latency", edges, 101);
    checkOutput("post_rst_result", result, 5050);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
